// File: rtl/sram_ctrl_pkg.sv
// Shared definitions for the SRAM access sequencer.
// Holds the controller state encoding, default bus widths and the phase timer width.
// No logic; imported by the controller and its phase timer.
package sram_ctrl_pkg;

  localparam int DEF_ROW_ADDR_WIDTH = 4;
  localparam int DEF_COL_ADDR_WIDTH = 4;
  localparam int DEF_DATA_WIDTH     = 8;

  // Phase timer width; bounds PRE_CYCLES and WL_CYCLES to 1..15.
  localparam int TIMER_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_PRECHARGE = 2'd1,
    ST_ACCESS    = 2'd2,
    ST_DONE      = 2'd3
  } state_e;

endpackage

// File: rtl/sram_phase_timer.sv
// Loadable down-counter shared by the precharge and access phases.
// Ports: load_i/load_val_i reload the count, dec_i decrements (saturating at 0);
// cnt_o is the current count, cnt_nxt_o the value after the coming edge, zero_o flags cnt_o==0.
module sram_phase_timer
  import sram_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_i,
  input  logic [TIMER_W-1:0] load_val_i,
  input  logic               dec_i,
  output logic [TIMER_W-1:0] cnt_o,
  output logic [TIMER_W-1:0] cnt_nxt_o,
  output logic               zero_o
);

  logic [TIMER_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o     = cnt_q;
  assign cnt_nxt_o = cnt_d;
  assign zero_o    = (cnt_q == '0);

endmodule

// File: rtl/sram_access_ctrl.sv
// Single-port SRAM access sequencer: accepts one request, latches {row,col}, data and op,
// then drives registered strobes: precharge -> wordline/column select with sense or write enable.
// Ports: req_* handshake in, rsp_valid/rsp_rdata out, row/col/strobe/write_data to array, bl_rdata from sense amps.
module sram_access_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int ROW_ADDR_WIDTH = DEF_ROW_ADDR_WIDTH,
  parameter int COL_ADDR_WIDTH = DEF_COL_ADDR_WIDTH,
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int PRE_CYCLES     = 1,
  parameter int WL_CYCLES      = 2
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     req_valid,
  output logic                                     req_ready,
  input  logic                                     req_we,
  input  logic [ROW_ADDR_WIDTH+COL_ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0]                    req_wdata,
  output logic                                     rsp_valid,
  output logic [DATA_WIDTH-1:0]                    rsp_rdata,
  output logic [ROW_ADDR_WIDTH-1:0]                row_addr,
  output logic                                     row_en,
  output logic [COL_ADDR_WIDTH-1:0]                col_addr,
  output logic                                     col_en,
  output logic                                     precharge_en,
  output logic                                     sense_en,
  output logic                                     write_en,
  output logic [DATA_WIDTH-1:0]                    write_data,
  input  logic [DATA_WIDTH-1:0]                    bl_rdata
);

  localparam logic [TIMER_W-1:0] PRE_LOAD = TIMER_W'(PRE_CYCLES - 1);
  localparam logic [TIMER_W-1:0] WL_LOAD  = TIMER_W'(WL_CYCLES - 1);

  state_e state_q, state_d;

  logic                      we_q;
  logic [ROW_ADDR_WIDTH-1:0] row_addr_q;
  logic [COL_ADDR_WIDTH-1:0] col_addr_q;
  logic [DATA_WIDTH-1:0]     write_data_q;
  logic [DATA_WIDTH-1:0]     rsp_rdata_q;
  logic                      rsp_valid_q;
  logic                      precharge_en_q, row_en_q, col_en_q, sense_en_q, write_en_q;

  logic                      accept;
  logic                      tmr_load, tmr_dec, tmr_zero;
  logic [TIMER_W-1:0]        tmr_load_val, tmr_cnt, tmr_nxt;
  logic                      sense_d, capture;

  assign accept = (state_q == ST_IDLE) && req_valid;

  sram_phase_timer u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (tmr_load),
    .load_val_i (tmr_load_val),
    .dec_i      (tmr_dec),
    .cnt_o      (tmr_cnt),
    .cnt_nxt_o  (tmr_nxt),
    .zero_o     (tmr_zero)
  );

  always_comb begin
    state_d      = state_q;
    tmr_load     = 1'b0;
    tmr_load_val = '0;
    tmr_dec      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          tmr_load     = 1'b1;
          tmr_load_val = PRE_LOAD;
          state_d      = ST_PRECHARGE;
        end
      end
      ST_PRECHARGE: begin
        if (tmr_zero) begin
          tmr_load     = 1'b1;
          tmr_load_val = WL_LOAD;
          state_d      = ST_ACCESS;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      ST_ACCESS: begin
        if (tmr_zero) begin
          state_d = ST_DONE;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Strobes are registered from the next state so they change only on clock edges.
  // The read's final access cycle is the one whose timer count will be zero.
  assign sense_d = (state_d == ST_ACCESS) && !we_q && (tmr_nxt == '0);
  // Sense data is taken at the edge that closes the sense_en cycle.
  assign capture = (state_q == ST_ACCESS) && tmr_zero && !we_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      we_q           <= 1'b0;
      row_addr_q     <= '0;
      col_addr_q     <= '0;
      write_data_q   <= '0;
      rsp_rdata_q    <= '0;
      rsp_valid_q    <= 1'b0;
      precharge_en_q <= 1'b0;
      row_en_q       <= 1'b0;
      col_en_q       <= 1'b0;
      sense_en_q     <= 1'b0;
      write_en_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      rsp_valid_q    <= (state_d == ST_DONE);
      precharge_en_q <= (state_d == ST_PRECHARGE);
      row_en_q       <= (state_d == ST_ACCESS);
      col_en_q       <= (state_d == ST_ACCESS);
      sense_en_q     <= sense_d;
      write_en_q     <= (state_d == ST_ACCESS) && we_q;
      if (accept) begin
        we_q         <= req_we;
        row_addr_q   <= req_addr[ROW_ADDR_WIDTH+COL_ADDR_WIDTH-1:COL_ADDR_WIDTH];
        col_addr_q   <= req_addr[COL_ADDR_WIDTH-1:0];
        write_data_q <= req_wdata;
      end
      if (capture) begin
        rsp_rdata_q <= bl_rdata;
      end
    end
  end

  assign req_ready    = (state_q == ST_IDLE);
  assign rsp_valid    = rsp_valid_q;
  assign rsp_rdata    = rsp_rdata_q;
  assign row_addr     = row_addr_q;
  assign col_addr     = col_addr_q;
  assign write_data   = write_data_q;
  assign precharge_en = precharge_en_q;
  assign row_en       = row_en_q;
  assign col_en       = col_en_q;
  assign sense_en     = sense_en_q;
  assign write_en     = write_en_q;

endmodule

// File: tb/tb_sram_access_ctrl.sv
module tb_sram_access_ctrl;

  typedef struct packed {
    logic       ready;
    logic       pre;
    logic       row_en;
    logic       col_en;
    logic       sense;
    logic       wr;
    logic       rspv;
    logic [7:0] rdata;
    logic [3:0] row;
    logic [3:0] col;
    logic [7:0] wdata;
  } obs_t;

  typedef struct packed {
    logic       valid;
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] bl;
  } in_t;

  typedef struct packed {
    in_t  i;
    obs_t o;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // default-timing DUT
  logic       req_valid = 1'b0, req_we = 1'b0;
  logic [7:0] req_addr = '0, req_wdata = '0, bl_rdata = '0;
  logic       req_ready, rsp_valid, row_en, col_en, precharge_en, sense_en, write_en;
  logic [7:0] rsp_rdata, write_data;
  logic [3:0] row_addr, col_addr;

  // PRE_CYCLES=3, WL_CYCLES=1 DUT
  logic       req_valid2 = 1'b0, req_we2 = 1'b0;
  logic [7:0] req_addr2 = '0, req_wdata2 = '0, bl_rdata2 = '0;
  logic       req_ready2, rsp_valid2, row_en2, col_en2, precharge_en2, sense_en2, write_en2;
  logic [7:0] rsp_rdata2, write_data2;
  logic [3:0] row_addr2, col_addr2;

  sram_access_ctrl dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .row_addr(row_addr), .row_en(row_en), .col_addr(col_addr), .col_en(col_en),
    .precharge_en(precharge_en), .sense_en(sense_en), .write_en(write_en),
    .write_data(write_data), .bl_rdata(bl_rdata)
  );

  sram_access_ctrl #(.PRE_CYCLES(3), .WL_CYCLES(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid2), .req_ready(req_ready2), .req_we(req_we2),
    .req_addr(req_addr2), .req_wdata(req_wdata2), .rsp_valid(rsp_valid2), .rsp_rdata(rsp_rdata2),
    .row_addr(row_addr2), .row_en(row_en2), .col_addr(col_addr2), .col_en(col_en2),
    .precharge_en(precharge_en2), .sense_en(sense_en2), .write_en(write_en2),
    .write_data(write_data2), .bl_rdata(bl_rdata2)
  );

  obs_t obs, obs2;
  assign obs  = '{req_ready, precharge_en, row_en, col_en, sense_en, write_en, rsp_valid,
                  rsp_rdata, row_addr, col_addr, write_data};
  assign obs2 = '{req_ready2, precharge_en2, row_en2, col_en2, sense_en2, write_en2, rsp_valid2,
                  rsp_rdata2, row_addr2, col_addr2, write_data2};

  int checks = 0;
  int errors = 0;
  vec_t vec [11];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Advance to the next falling edge and check the strobe invariants on both DUTs.
  task automatic tick();
    @(negedge clk);
    chk("inv_pre_row",  {62'd0, precharge_en & row_en}, 64'd0);
    chk("inv_sense_wr", {62'd0, sense_en & write_en}, 64'd0);
    chk("inv_pre_row2", {62'd0, precharge_en2 & row_en2}, 64'd0);
    chk("inv_sense_wr2",{62'd0, sense_en2 & write_en2}, 64'd0);
  endtask

  initial begin
    int last;
    int cyc;
    int k;
    logic [3:0] exp_row, exp_col;
    bit got_rsp;
    obs_t e;

    //            valid we   addr   wdata  bl            ready pre row col sen wr rspv rdata row   col   wdata
    vec[0]  = '{'{1'b1,1'b0,8'h3A,8'h00,8'h00}, '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,8'h00,4'h0,4'h0,8'h00}};
    vec[1]  = '{'{1'b0,1'b0,8'h00,8'h00,8'h00}, '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,8'h00,4'h3,4'hA,8'h00}};
    vec[2]  = '{'{1'b0,1'b0,8'h00,8'h00,8'h00}, '{1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,8'h00,4'h3,4'hA,8'h00}};
    vec[3]  = '{'{1'b0,1'b0,8'h00,8'h00,8'hC5}, '{1'b0,1'b0,1'b1,1'b1,1'b1,1'b0,1'b0,8'h00,4'h3,4'hA,8'h00}};
    vec[4]  = '{'{1'b0,1'b0,8'h00,8'h00,8'h00}, '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,8'hC5,4'h3,4'hA,8'h00}};
    vec[5]  = '{'{1'b1,1'b1,8'hF0,8'h5A,8'h00}, '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,8'hC5,4'h3,4'hA,8'h00}};
    vec[6]  = '{'{1'b0,1'b0,8'h00,8'h00,8'h33}, '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,8'hC5,4'hF,4'h0,8'h5A}};
    vec[7]  = '{'{1'b0,1'b0,8'h00,8'h00,8'h33}, '{1'b0,1'b0,1'b1,1'b1,1'b0,1'b1,1'b0,8'hC5,4'hF,4'h0,8'h5A}};
    vec[8]  = '{'{1'b0,1'b0,8'h00,8'h00,8'h33}, '{1'b0,1'b0,1'b1,1'b1,1'b0,1'b1,1'b0,8'hC5,4'hF,4'h0,8'h5A}};
    vec[9]  = '{'{1'b0,1'b0,8'h00,8'h00,8'h33}, '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,8'hC5,4'hF,4'h0,8'h5A}};
    vec[10] = '{'{1'b0,1'b0,8'h00,8'h00,8'h00}, '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,8'hC5,4'hF,4'h0,8'h5A}};

    // Reset
    repeat (2) @(negedge clk);
    chk("reset_obs",  64'(obs),  64'(obs_t'({1'b1, 30'd0})));
    chk("reset_obs2", 64'(obs2), 64'(obs_t'({1'b1, 30'd0})));
    rst_n = 1'b1;

    // Read 0x3A then write 0xF0, cycle by cycle
    for (int i = 0; i < 11; i++) begin
      tick();
      req_valid = vec[i].i.valid;
      req_we    = vec[i].i.we;
      req_addr  = vec[i].i.addr;
      req_wdata = vec[i].i.wdata;
      bl_rdata  = vec[i].i.bl;
      #1;
      chk($sformatf("vec%0d", i), 64'(obs), 64'(vec[i].o));
    end

    // req_valid held high with a changing address: accept every 5 cycles
    last = -1;
    exp_row = '0;
    exp_col = '0;
    for (cyc = 0; cyc < 22; cyc++) begin
      tick();
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_addr  = 8'(cyc * 37 + 5);
      bl_rdata  = 8'(cyc);
      #1;
      if (req_ready) begin
        if (last >= 0) chk("b2b_accept_gap", 64'(cyc - last), 64'd5);
        exp_row = req_addr[7:4];
        exp_col = req_addr[3:0];
        last = cyc;
      end else if (last >= 0) begin
        chk("b2b_busy_window", 64'((cyc - last) <= 4), 64'd1);
        chk("b2b_addr_stable", {56'd0, row_addr, col_addr}, {56'd0, exp_row, exp_col});
      end else begin
        chk("b2b_first_ready", 64'(req_ready), 64'd1);
      end
    end
    req_valid = 1'b0;
    k = 0;
    while (!req_ready && k < 10) begin
      tick();
      k++;
    end
    chk("b2b_drain_ready", 64'(req_ready), 64'd1);

    // PRE_CYCLES=3, WL_CYCLES=1 read on the second DUT
    tick();
    req_valid2 = 1'b1;
    req_we2    = 1'b0;
    req_addr2  = 8'h5C;
    for (k = 1; k <= 6; k++) begin
      tick();
      req_valid2 = 1'b0;
      bl_rdata2  = (k == 4) ? 8'h77 : 8'h11;
      #1;
      e = '{(k >= 6), (k <= 3), (k == 4), (k == 4), (k == 4), 1'b0, (k == 5),
            (k >= 5) ? 8'h77 : 8'h00, 4'h5, 4'hC, 8'h00};
      chk($sformatf("p3w1_T%0d", k), 64'(obs2), 64'(e));
    end

    // Reset asserted in the middle of a write's ACCESS phase
    tick();
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 8'h81;
    req_wdata = 8'hE7;
    tick();
    req_valid = 1'b0;
    req_we    = 1'b0;
    tick();
    #1;
    chk("rst_pre_write_en", 64'(write_en), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async_obs", 64'(obs), 64'(obs_t'({1'b1, 30'd0})));
    tick();
    tick();
    rst_n = 1'b1;
    got_rsp = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (rsp_valid) got_rsp = 1'b1;
      chk("rst_ready_after", 64'(req_ready), 64'd1);
    end
    chk("rst_no_rsp", 64'(got_rsp), 64'd0);

    // Normal read after the reset
    tick();
    req_valid = 1'b1;
    req_addr  = 8'h12;
    bl_rdata  = 8'h9E;
    tick();
    req_valid = 1'b0;
    k = 0;
    while (!rsp_valid && k < 12) begin
      tick();
      k++;
    end
    chk("post_rst_rsp_seen", 64'(rsp_valid), 64'd1);
    chk("post_rst_rdata", 64'(rsp_rdata), 64'h9E);
    chk("post_rst_addr", {56'd0, row_addr, col_addr}, 64'h12);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_access_ctrl.md
# sram_access_ctrl

Single-port access sequencer that sits directly upstream of the SRAM row and column decoders. It accepts one read or write request at a time, latches and splits the address, and drives a fixed, non-overlapping strobe sequence: precharge, then wordline/column select with sense or write enable. It returns read data, or a write acknowledge, on a one-cycle response pulse. All array-side strobes are registered, so the decoders and drivers never see combinational glitches.

## Interface
Parameters:
- ROW_ADDR_WIDTH, 4, row address bits fed to the row decoder
- COL_ADDR_WIDTH, 4, column address bits fed to the column decoder (16 one-hot columns)
- DATA_WIDTH, 8, width of write data and sensed read data
- PRE_CYCLES, 1, precharge phase length in cycles (legal 1..15)
- WL_CYCLES, 2, wordline/access phase length in cycles (legal 1..15)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  controller idle; a request is accepted when req_valid & req_ready
- req_we  in  1  1 = write, 0 = read
- req_addr  in  ROW_ADDR_WIDTH+COL_ADDR_WIDTH  {row, col}; col in the low COL_ADDR_WIDTH bits
- req_wdata  in  DATA_WIDTH  write data
- rsp_valid  out  1  one-cycle completion pulse (read or write)
- rsp_rdata  out  DATA_WIDTH  last captured read data
- row_addr  out  ROW_ADDR_WIDTH  latched row address
- row_en  out  1  row decoder enable (wordline on)
- col_addr  out  COL_ADDR_WIDTH  latched column address
- col_en  out  1  column decoder enable
- precharge_en  out  1  bitline precharge active
- sense_en  out  1  sense-amp enable (reads only)
- write_en  out  1  write-driver enable (writes only)
- write_data  out  DATA_WIDTH  latched write data
- bl_rdata  in  DATA_WIDTH  sense-amp output, valid while sense_en=1

## Operation
- States: IDLE, PRECHARGE, ACCESS, DONE.
- IDLE: req_ready=1 and all strobes are 0. On accept:
  - latch row_addr, col_addr, write_data and the op type;
  - load the phase timer with PRE_CYCLES-1;
  - go to PRECHARGE.
- PRECHARGE: precharge_en=1 for exactly PRE_CYCLES cycles. When the timer reaches 0, load WL_CYCLES-1 and go to ACCESS.
- ACCESS lasts exactly WL_CYCLES cycles with row_en=1 and col_en=1.
  - Write: write_en=1 in every ACCESS cycle.
  - Read: sense_en=1 in the last ACCESS cycle only. bl_rdata is captured into rsp_rdata at the closing edge of that cycle.
  - When the timer reaches 0, go to DONE.
- DONE: rsp_valid=1 for one cycle, all strobes are 0, then return to IDLE.
- Invariants:
  - precharge_en and row_en are never high in the same cycle.
  - sense_en and write_en are mutually exclusive.
  - Latched address and data stay stable from accept until IDLE is re-entered.
- rsp_rdata holds its value across writes and changes only on read capture.
- There is no response backpressure. req_valid while busy is ignored (req_ready=0), with no queuing.
- Reset (async, any state, including mid-ACCESS):
  - state returns to IDLE and req_ready=1;
  - rsp_valid, row_en, col_en, precharge_en, sense_en and write_en go to 0;
  - row_addr, col_addr, write_data and rsp_rdata go to 0;
  - the in-flight op is dropped with no rsp_valid.

## Timing
- Accept edge is T0. The strobes below are registered outputs.
- PRECHARGE: cycles T0+1 .. T0+PRE_CYCLES.
- ACCESS: the next WL_CYCLES cycles.
- DONE (rsp_valid=1): cycle T0+PRE_CYCLES+WL_CYCLES+1.
- req_ready returns to 1 the cycle after DONE.
- Default throughput is one op per 5 cycles (PRE+WL+2).
- With defaults: precharge at T1, ACCESS at T2–T3, sense_en at T3, rsp_valid at T4, next accept possible at edge T5.
- The phase timer is 4 bits.

## Structure
- Shared package sram_ctrl_pkg holds:
  - the state enum (IDLE, PRECHARGE, ACCESS, DONE);
  - default ROW_ADDR_WIDTH, COL_ADDR_WIDTH and DATA_WIDTH;
  - the timer width constant.
- Sub-module sram_phase_timer: a loadable 4-bit down-counter with a zero flag and async active-low reset, shared by the PRECHARGE and ACCESS phases.

## Test plan
- Reset, then a read at addr 8'h3A with bl_rdata=8'hC5 during sense_en:
  - row_addr=3, col_addr=A;
  - precharge at T1, row_en/col_en at T2–T3, sense_en only at T3;
  - rsp_valid at T4 with rsp_rdata=8'hC5.
- Write addr 8'hF0, wdata 8'h5A:
  - write_en=1 at T2–T3, write_data=8'h5A, sense_en never set;
  - rsp_valid at T4, rsp_rdata unchanged.
- req_valid held high continuously:
  - accepts occur exactly every 5 cycles;
  - req_ready=0 from T1 through T4;
  - changes to req_addr while busy do not alter row_addr/col_addr.
- PRE_CYCLES=3, WL_CYCLES=1 read: precharge_en for 3 cycles, a single ACCESS cycle that also carries sense_en, rsp_valid at T5.
- Check on every cycle: precharge_en & row_en never both 1, and sense_en & write_en never both 1.
- Deassert rst_n in the middle of ACCESS of a write:
  - all strobes drop immediately (asynchronously);
  - no rsp_valid;
  - req_ready=1 after release;
  - the next read completes normally.
